// File: rtl/m_phy_rx_pwm_decoder.sv
// M-PHY Type-1 RX PWM decoder: bit widths -> LSB-first 10-bit symbols plus burst-exit strobes.
// Outputs are registered one cycle after the deciding line sample; no backpressure, all strobes are single-cycle.
module m_phy_rx_pwm_decoder #(
  parameter int T_PREPARE_MIN  = 8,
  parameter int T_MAX_HIGH     = 30,
  parameter int T_END_OF_BURST = 40,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] phy_state,
  input  logic [1:0] line_state,
  input  logic       line_cfg_req,
  output logic [9:0] symbol,
  output logic       symbol_valid,
  output logic       symbol_err,
  output logic       pwm_2_sleep,
  output logic       pwm_2_line_cfg,
  output logic       burst_active
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREPARE = 3'd1;
  localparam logic [2:0] S_HIGH    = 3'd2;
  localparam logic [2:0] S_LOW     = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  localparam logic [1:0] LS_DIF_N = 2'd0;
  localparam logic [1:0] LS_DIF_P = 2'd1;
  localparam logic [1:0] LS_DIF_Q = 2'd2;
  localparam logic [1:0] LS_DIF_Z = 2'd3;

  localparam logic [1:0] PHY_PWM_BURST = 2'b01;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] PREP_MIN  = CNT_W'(T_PREPARE_MIN);
  localparam logic [CNT_W-1:0] MAX_HIGH  = CNT_W'(T_MAX_HIGH);
  localparam logic [CNT_W-1:0] EOB_LIMIT = CNT_W'(T_END_OF_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]       state, state_d;
  logic [CNT_W-1:0] h_cnt, h_d, l_cnt, l_d;
  logic [CNT_W-1:0] h_inc, l_inc;
  logic [CNT_W:0]   h_plus1;
  logic [1:0]       line_state_r;
  logic             bit_pending, pend_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt, bcnt_d;
  logic [9:0]       sym_d;
  logic             vld_d, err_d, sleep_d, cfg_d;

  logic rise, fall, line_bad, in_burst;
  logic res_vld, res_bit, to_err, eob;

  assign in_burst = (phy_state == PHY_PWM_BURST);
  assign rise     = (line_state_r == LS_DIF_N) && (line_state == LS_DIF_P);
  assign fall     = (line_state_r == LS_DIF_P) && (line_state == LS_DIF_N);
  assign line_bad = (line_state == LS_DIF_Q) || (line_state == LS_DIF_Z);
  assign h_inc    = (h_cnt == CNT_MAX) ? h_cnt : h_cnt + CNT_ONE;
  assign l_inc    = (l_cnt == CNT_MAX) ? l_cnt : l_cnt + CNT_ONE;
  assign h_plus1  = {1'b0, h_cnt} + {{CNT_W{1'b0}}, 1'b1};

  assign burst_active = (state == S_PREPARE) || (state == S_HIGH) || (state == S_LOW);

  always_comb begin
    state_d = state;
    h_d     = h_cnt;
    l_d     = l_cnt;
    pend_d  = bit_pending;
    shift_d = shift_q;
    bcnt_d  = bit_cnt;
    sym_d   = symbol;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    sleep_d = 1'b0;
    cfg_d   = 1'b0;
    res_vld = 1'b0;
    res_bit = 1'b0;
    to_err  = 1'b0;
    eob     = 1'b0;

    if (!in_burst) begin
      // Leaving PWM_BURST aborts everything silently, whatever the state.
      state_d = S_IDLE;
      h_d     = '0;
      l_d     = '0;
      pend_d  = 1'b0;
      shift_d = '0;
      bcnt_d  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (line_state == LS_DIF_P) begin
            state_d = S_PREPARE;
            h_d     = CNT_ONE;
            l_d     = '0;
            pend_d  = 1'b0;
            shift_d = '0;
            bcnt_d  = '0;
          end
        end
        S_PREPARE: begin
          if (line_bad) begin
            to_err = 1'b1;
          end else if (fall) begin
            if (h_cnt >= PREP_MIN) begin
              state_d = S_LOW;
              l_d     = CNT_ONE;
              pend_d  = 1'b0;
            end else begin
              to_err = 1'b1;
            end
          end else if (line_state == LS_DIF_P) begin
            h_d = h_inc;
          end
        end
        S_HIGH: begin
          if (line_bad) begin
            to_err = 1'b1;
          end else if (fall) begin
            state_d = S_LOW;
            l_d     = CNT_ONE;
            pend_d  = 1'b1;
          end else if (line_state == LS_DIF_P) begin
            if (h_inc > MAX_HIGH) begin
              to_err = 1'b1;
            end else begin
              h_d = h_inc;
            end
          end
        end
        S_LOW: begin
          if (line_bad) begin
            to_err = 1'b1;
          end else if (rise) begin
            if (bit_pending && (l_cnt == h_cnt)) begin
              to_err = 1'b1;
            end else begin
              if (bit_pending && (l_cnt < h_cnt)) begin
                res_vld = 1'b1;
                res_bit = 1'b1;
              end
              state_d = S_HIGH;
              h_d     = CNT_ONE;
              l_d     = '0;
              pend_d  = 1'b0;
            end
          end else if (line_state == LS_DIF_N) begin
            l_d = l_inc;
            // A low run longer than the high run settles the pending bit as 0.
            if (bit_pending && ({1'b0, l_inc} == h_plus1)) begin
              res_vld = 1'b1;
              res_bit = 1'b0;
              pend_d  = 1'b0;
            end
            if (l_inc == EOB_LIMIT) begin
              eob = 1'b1;
            end
          end
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (res_vld) begin
        if (bit_cnt == 4'd9) begin
          sym_d   = {res_bit, shift_q};
          vld_d   = 1'b1;
          bcnt_d  = '0;
          shift_d = '0;
        end else begin
          shift_d[bit_cnt] = res_bit;
          bcnt_d           = bit_cnt + 4'd1;
        end
      end

      if (eob) begin
        state_d = S_IDLE;
        err_d   = (bcnt_d != 4'd0);
        sleep_d = !line_cfg_req;
        cfg_d   = line_cfg_req;
        h_d     = '0;
        l_d     = '0;
        pend_d  = 1'b0;
        shift_d = '0;
        bcnt_d  = '0;
      end

      // An error wins over any symbol completing in the same cycle.
      if (to_err) begin
        state_d = S_ERROR;
        err_d   = 1'b1;
        vld_d   = 1'b0;
        sleep_d = 1'b0;
        cfg_d   = 1'b0;
        sym_d   = symbol;
        pend_d  = 1'b0;
        shift_d = '0;
        bcnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      h_cnt          <= '0;
      l_cnt          <= '0;
      line_state_r   <= LS_DIF_N;
      bit_pending    <= 1'b0;
      shift_q        <= '0;
      bit_cnt        <= '0;
      symbol         <= '0;
      symbol_valid   <= 1'b0;
      symbol_err     <= 1'b0;
      pwm_2_sleep    <= 1'b0;
      pwm_2_line_cfg <= 1'b0;
    end else begin
      state          <= state_d;
      h_cnt          <= h_d;
      l_cnt          <= l_d;
      line_state_r   <= line_state;
      bit_pending    <= pend_d;
      shift_q        <= shift_d;
      bit_cnt        <= bcnt_d;
      symbol         <= sym_d;
      symbol_valid   <= vld_d;
      symbol_err     <= err_d;
      pwm_2_sleep    <= sleep_d;
      pwm_2_line_cfg <= cfg_d;
    end
  end

endmodule

// File: tb/tb_m_phy_rx_pwm_decoder.sv
// Bench for m_phy_rx_pwm_decoder: bursts described as (high, low) widths, scoreboarded events.
// Expected events carry the cycle they must appear in; a forked monitor pops and compares them.
module tb_m_phy_rx_pwm_decoder;

  localparam int T_EOB = 40;
  localparam logic [1:0] DN = 2'd0;
  localparam logic [1:0] DP = 2'd1;
  localparam logic [1:0] DQ = 2'd2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] phy_state;
  logic [1:0] line_state;
  logic       line_cfg_req;
  logic [9:0] symbol;
  logic       symbol_valid, symbol_err, pwm_2_sleep, pwm_2_line_cfg, burst_active;

  typedef struct {
    int         cyc;
    logic       vld;
    logic       err;
    logic       slp;
    logic       cfg;
    logic [9:0] sym;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [9:0] acc;
  int         cnt;
  logic [31:0] pat;

  m_phy_rx_pwm_decoder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .phy_state      (phy_state),
    .line_state     (line_state),
    .line_cfg_req   (line_cfg_req),
    .symbol         (symbol),
    .symbol_valid   (symbol_valid),
    .symbol_err     (symbol_err),
    .pwm_2_sleep    (pwm_2_sleep),
    .pwm_2_line_cfg (pwm_2_line_cfg),
    .burst_active   (burst_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic v, input logic e, input logic s,
                         input logic f, input logic [9:0] sy);
    ev_t ev;
    ev.cyc = c; ev.vld = v; ev.err = e; ev.slp = s; ev.cfg = f; ev.sym = sy;
    exp_q.push_back(ev);
  endtask

  // A bit settled on drive cycle rc becomes visible one cycle later.
  task automatic add_bit(input logic b, input int rc);
    acc = acc | (10'(b) << cnt);
    cnt++;
    if (cnt == 10) begin
      push_ev(rc + 1, 1'b1, 1'b0, 1'b0, 1'b0, acc);
      cnt = 0;
      acc = '0;
    end
  endtask

  task automatic drive(input logic [1:0] ls);
    line_state = ls;
    @(posedge clk);
    #1;
  endtask

  // Bit value: low shorter than high is 1, longer is 0. The final bit is always 0
  // because its low run stretches into the end-of-burst run.
  task automatic burst(input int nbits, input logic [31:0] p, input bit rnd,
                       input bit cfg, input int abort_at);
    int  h, l, t0, n;
    bit  pend1;
    line_cfg_req = cfg;
    phy_state    = 2'b01;
    acc = '0; cnt = 0; pend1 = 0;
    n = rnd ? $urandom_range(14, 8) : 10;
    repeat (n) drive(DP);
    n = rnd ? $urandom_range(10, 1) : 2;
    repeat (n) drive(DN);
    for (int i = 0; i < nbits && i != abort_at; i++) begin
      if (i == nbits - 1)  h = rnd ? $urandom_range(12, 1) : 2;
      else if (p[i])      h = rnd ? $urandom_range(12, 2) : 6;
      else                h = rnd ? $urandom_range(12, 1) : 2;
      if (pend1) add_bit(1'b1, cyc);
      pend1 = 0;
      repeat (h) drive(DP);
      t0 = cyc;
      if (i == nbits - 1) begin
        add_bit(1'b0, t0 + h);
        push_ev(t0 + T_EOB, 1'b0, cnt != 0, !cfg, cfg, 10'd0);
        acc = '0; cnt = 0;
        repeat (T_EOB) drive(DN);
        repeat (3) drive(DN);
        chk("burst_active_after_eob", burst_active, 0);
      end else if (p[i]) begin
        l = rnd ? $urandom_range(h - 1, 1) : 2;
        pend1 = 1;
        repeat (l) drive(DN);
      end else begin
        l = rnd ? $urandom_range(h + 12, h + 1) : 6;
        add_bit(1'b0, t0 + h);
        repeat (l) drive(DN);
      end
    end
  endtask

  initial begin
    int f;
    reset_n = 1'b0; phy_state = 2'b00; line_state = DN; line_cfg_req = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (reset_n && (symbol_valid || symbol_err || pwm_2_sleep || pwm_2_line_cfg)) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", {symbol_valid, symbol_err, pwm_2_sleep, pwm_2_line_cfg}, 0);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("event_cycle", cyc, e.cyc);
            chk("event_flags", {symbol_valid, symbol_err, pwm_2_sleep, pwm_2_line_cfg},
                {e.vld, e.err, e.slp, e.cfg});
            if (e.vld) chk("event_symbol", symbol, e.sym);
          end
        end
      end
    join_none

    #1;
    chk("rst_symbol", symbol, 0);
    chk("rst_valid", symbol_valid, 0);
    chk("rst_err", symbol_err, 0);
    chk("rst_sleep", pwm_2_sleep, 0);
    chk("rst_line_cfg", pwm_2_line_cfg, 0);
    chk("rst_active", burst_active, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) drive(DN);

    // Reference bursts: 1010011100 exiting to SLEEP, then to LINE-CFG.
    burst(10, 32'h0E5, 0, 0, -1);
    burst(10, 32'h0E5, 0, 1, -1);

    // Too-short PREPARE; the decoder must then ignore a whole valid-looking burst.
    phy_state = 2'b01;
    repeat (5) drive(DP);
    f = cyc;
    push_ev(f + 1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    drive(DN);
    chk("active_in_error", burst_active, 0);
    repeat (10) drive(DP);
    repeat (2) drive(DN);
    for (int i = 0; i < 12; i++) begin
      repeat (i[0] ? 6 : 2) drive(DP);
      repeat (i[0] ? 2 : 6) drive(DN);
    end
    repeat (T_EOB + 5) drive(DN);
    phy_state = 2'b00;
    drive(DN);

    // Bit with equal high and low widths.
    phy_state = 2'b01;
    repeat (10) drive(DP);
    repeat (2) drive(DN);
    chk("active_in_low", burst_active, 1);
    repeat (4) drive(DP);
    repeat (4) drive(DN);
    push_ev(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    drive(DP);
    repeat (3) drive(DP);
    repeat (T_EOB + 5) drive(DN);
    chk("active_err_hold", burst_active, 0);
    phy_state = 2'b00;
    drive(DN);

    // Line fault inside a bit.
    phy_state = 2'b01;
    repeat (10) drive(DP);
    repeat (2) drive(DN);
    repeat (3) drive(DP);
    push_ev(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    drive(DQ);
    repeat (3) drive(DN);
    phy_state = 2'b00;
    drive(DN);

    // Four-bit partial burst.
    burst(4, 32'h5, 0, 0, -1);

    // phy_state drop mid-symbol, then a fresh burst.
    burst(8, 32'h2D, 1, 0, 5);
    phy_state = 2'b00;
    drive(DN);
    chk("active_after_drop", burst_active, 0);
    burst(10, 32'h1B3, 1, 0, -1);

    // Asynchronous reset mid-symbol after one full symbol.
    pat = 32'h000B_5A6D;
    burst(20, pat, 0, 0, 15);
    chk("sym_before_reset", symbol, pat[9:0]);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_symbol", symbol, 0);
    chk("arst_valid", symbol_valid, 0);
    chk("arst_err", symbol_err, 0);
    chk("arst_sleep", pwm_2_sleep, 0);
    chk("arst_line_cfg", pwm_2_line_cfg, 0);
    chk("arst_active", burst_active, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) drive(DN);
    burst(10, 32'h2C6, 0, 1, -1);

    // Randomised bursts.
    for (int k = 0; k < 8; k++) begin
      int nb;
      nb  = $urandom_range(25, 1);
      pat = $urandom;
      pat[nb - 1] = 1'b0;
      burst(nb, pat, 1, 1'($urandom_range(1, 0)), -1);
    end

    repeat (3) drive(DN);
    chk("pending_events", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_phy_rx_pwm_decoder.md
Name: m_phy_rx_pwm_decoder

Overview:
- Decodes the PWM bit stream of a Type-1 M-PHY RX lane while the RX state machine reports PWM_BURST.
- Sits downstream of the line-state sampler and alongside the RX state machine.
- Consumes line_state and phy_state, and produces 10-bit symbols for the deserialiser.
- Generates the burst-exit strobes pwm_2_sleep and pwm_2_line_cfg, which the RX state machine consumes.

Parameters:
- T_PREPARE_MIN, 8: minimum DIF-P cycles of the PREPARE interval that opens a burst.
- T_MAX_HIGH, 30: DIF-P run longer than this inside a bit is an error.
- T_END_OF_BURST, 40: consecutive DIF-N cycles that mark end of burst.
- CNT_W, 16: width of the internal run counters; counters saturate.

Ports:
- clk  in  1  lane clock.
- reset_n  in  1  asynchronous, active-low reset.
- phy_state  in  2  from RX state machine; 2'b01 = PWM_BURST.
- line_state  in  2  sampled line: 0=DIF-N, 1=DIF-P, 2=DIF-Q, 3=DIF-Z.
- line_cfg_req  in  1  sampled at end of burst; selects the LINE-CFG exit over SLEEP.
- symbol  out  10  decoded symbol, first received bit in bit 0.
- symbol_valid  out  1  one-cycle strobe; symbol is valid this cycle.
- symbol_err  out  1  one-cycle strobe on any decode error.
- pwm_2_sleep  out  1  one-cycle strobe: burst ended, return to SLEEP.
- pwm_2_line_cfg  out  1  one-cycle strobe: burst ended, enter LINE-CFG.
- burst_active  out  1  high while the decoder is in PREPARE, HIGH or LOW.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0, symbol=0; counters 0; line_state_r=DIF-N.
- line_state_r is line_state registered.
- Rising edge (rise) = line_state_r==DIF-N and line_state==DIF-P.
- Falling edge (fall) = line_state_r==DIF-P and line_state==DIF-N.
- H counts DIF-P cycles of the current bit; L counts DIF-N cycles. Both saturate at 2^CNT_W-1.
- States: IDLE, PREPARE, HIGH, LOW, ERROR.
- IDLE: on phy_state==01 and line_state==DIF-P -> PREPARE, with H=1.
- PREPARE: H increments each DIF-P cycle.
  - On fall with H>=T_PREPARE_MIN -> LOW, with L=1, no bit pending.
  - On fall with H<T_PREPARE_MIN -> ERROR.
- HIGH: H increments each DIF-P cycle.
  - On fall -> LOW, with L=1.
  - H>T_MAX_HIGH -> ERROR.
- LOW: L increments each DIF-N cycle.
  - Bit 0 resolves on the cycle L becomes H+1, with a pending bit only.
  - On rise with a bit pending: L<H resolves bit 1; L==H -> ERROR. Then go to HIGH with H=1, L=0.
  - L reaching T_END_OF_BURST = end of burst; the next state is IDLE.
- Symbol assembly: resolved bits shift in LSB-first; a 4-bit bit counter counts 0..9.
  - On the 10th bit, symbol is loaded and symbol_valid is high the cycle after the resolving cycle.
  - The bit counter wraps to 0.
- End of burst, strobed the cycle after L reaches T_END_OF_BURST:
  - Bit counter 0: pwm_2_line_cfg if line_cfg_req, else pwm_2_sleep.
  - Bit counter nonzero: symbol_err, plus the same exit strobe. The partial symbol is discarded.
- DIF-Q or DIF-Z seen in PREPARE, HIGH or LOW -> ERROR.
- Entering ERROR: symbol_err pulses once.
- ERROR: stays until phy_state!=01, then -> IDLE. No symbols and no exit strobes are produced.
- phy_state leaving 01 in any state -> IDLE next cycle.
  - The partial symbol is cleared silently; no strobes.
  - This has priority over all other transitions.
- Simultaneous events: a bit resolution and end of burst cannot coincide, because L>H fires first. An error has priority over symbol_valid in the same cycle.
- burst_active is high while the state is PREPARE, HIGH or LOW.
- symbol holds its last value between symbol_valid strobes.

Test Plan:
- Burst of 10 PWM bits, each bit either 1 (H=6, L=2) or 0 (H=2, L=6). Sequence is PREPARE of 10 DIF-P cycles, pattern 1010011100 first-to-last, then DIF-N for 40 cycles, line_cfg_req=0. Required: one symbol_valid with symbol=10'b0011100101, then exactly one pwm_2_sleep pulse 40 cycles after the last DIF-N run starts; burst_active then drops.
- Same as above with line_cfg_req=1 -> pwm_2_line_cfg pulses; pwm_2_sleep stays 0.
- PREPARE of 5 DIF-P cycles -> symbol_err one pulse; no symbol_valid until phy_state leaves 01.
- Bit with H=4, L=4 -> symbol_err at the rise; decoder holds ERROR; phy_state=00 -> IDLE.
- Burst of 4 bits, then end of burst -> symbol_err and pwm_2_sleep in the same cycle; no symbol_valid.
- Async reset_n pulse mid-symbol (bit 5) -> all outputs 0 immediately. After release, a fresh 10-bit burst decodes correctly; the stale bits do not appear.
